// File: rtl/qspi_fifo_buf.sv
// Dual FIFO buffer between the APB register file and the QSPI shift engine.
// Latency: first-word-fall-through, and a push is visible at the head one edge later.
// Backpressure: TX uses valid/ready and RX exposes ready. Pushes into a full FIFO are
// dropped and set overrun_o. An RX pop while empty sets underrun_o.
//
// Ports: pclk/preset (async, active-high); tx_we_i/tx_wdata_i push TX;
//   tx_valid_o/tx_rdata_o/tx_ready_i pop TX; rx_valid_i/rx_wdata_i/rx_ready_o push RX;
//   rx_re_i/rx_rdata_o pop RX; *_level_o, *_empty_o and *_full_o give status;
//   tx_empty_set_o/rx_full_set_o are interrupt pulses; overrun_o/underrun_o are sticky
//   error flags, cleared by err_clr_i.
// Optional: define QSPI_FIFO_FLUSH_EN to add tx_flush_i/rx_flush_i.

// Single FIFO with a separate level counter. Flush beats push/pop.
module qspi_fifo_buf_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [3:0]        level_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              drop_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]        level_q, level_d;
  logic              push_ok, pop_ok;

  assign empty_o = (level_q == 4'd0);
  assign full_o  = (level_q == 4'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop into an empty FIFO is ignored, even when a push arrives in the same cycle.
  // A full FIFO still takes a push when a pop frees the slot in the same cycle.
  assign pop_ok  = pop_i && !flush_i && !empty_o;
  assign push_ok = push_i && !flush_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !flush_i && !push_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = 4'd0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 4'd1;
        2'b01:   level_d = level_q - 4'd1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 4'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

module qspi_fifo_buf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              tx_we_i,
  input  logic [DATA_W-1:0] tx_wdata_i,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_rdata_o,
  input  logic              tx_ready_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_wdata_i,
  output logic              rx_ready_o,
  input  logic              rx_re_i,
  output logic [DATA_W-1:0] rx_rdata_o,
  output logic [3:0]        tx_level_o,
  output logic [3:0]        rx_level_o,
  output logic              tx_empty_o,
  output logic              tx_full_o,
  output logic              rx_empty_o,
  output logic              rx_full_o,
  output logic              tx_empty_set_o,
  output logic              rx_full_set_o,
  output logic              overrun_o,
  output logic              underrun_o,
`ifdef QSPI_FIFO_FLUSH_EN
  input  logic              tx_flush_i,
  input  logic              rx_flush_i,
`endif
  input  logic              err_clr_i
);
  logic tx_flush, rx_flush, tx_drop, rx_drop;
  logic tx_empty_prev_q, rx_full_prev_q;
  logic tx_empty_set_q, rx_full_set_q, overrun_q, underrun_q;
  logic overrun_d, underrun_d;

`ifdef QSPI_FIFO_FLUSH_EN
  assign tx_flush = tx_flush_i;
  assign rx_flush = rx_flush_i;
`else
  assign tx_flush = 1'b0;
  assign rx_flush = 1'b0;
`endif

  qspi_fifo_buf_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx (
    .clk_i(pclk), .rst_i(preset), .flush_i(tx_flush),
    .push_i(tx_we_i), .wdata_i(tx_wdata_i), .pop_i(tx_ready_i),
    .rdata_o(tx_rdata_o), .level_o(tx_level_o), .empty_o(tx_empty_o),
    .full_o(tx_full_o), .drop_o(tx_drop)
  );

  qspi_fifo_buf_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx (
    .clk_i(pclk), .rst_i(preset), .flush_i(rx_flush),
    .push_i(rx_valid_i), .wdata_i(rx_wdata_i), .pop_i(rx_re_i),
    .rdata_o(rx_rdata_o), .level_o(rx_level_o), .empty_o(rx_empty_o),
    .full_o(rx_full_o), .drop_o(rx_drop)
  );

  assign tx_valid_o = !tx_empty_o;
  assign rx_ready_o = !rx_full_o;

  // Setting a sticky flag wins over a clear in the same cycle.
  assign overrun_d  = (tx_drop || rx_drop) ? 1'b1 : (err_clr_i ? 1'b0 : overrun_q);
  assign underrun_d = (rx_re_i && rx_empty_o && !rx_flush) ? 1'b1 :
                      (err_clr_i ? 1'b0 : underrun_q);

  // The previous-empty register resets to 1 so that leaving reset does not
  // look like a transition into empty.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tx_empty_prev_q <= 1'b1;
      rx_full_prev_q  <= 1'b0;
      tx_empty_set_q  <= 1'b0;
      rx_full_set_q   <= 1'b0;
      overrun_q       <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      tx_empty_prev_q <= tx_empty_o;
      rx_full_prev_q  <= rx_full_o;
      tx_empty_set_q  <= tx_empty_o && !tx_empty_prev_q;
      rx_full_set_q   <= rx_full_o && !rx_full_prev_q;
      overrun_q       <= overrun_d;
      underrun_q      <= underrun_d;
    end
  end

  assign tx_empty_set_o = tx_empty_set_q;
  assign rx_full_set_o  = rx_full_set_q;
  assign overrun_o      = overrun_q;
  assign underrun_o     = underrun_q;
endmodule

// File: tb/tb_qspi_fifo_buf.sv
module tb_qspi_fifo_buf;
  logic        pclk = 1'b0;
  logic        preset;
  logic        tx_we_i = 0, tx_ready_i = 0, rx_valid_i = 0, rx_re_i = 0, err_clr_i = 0;
  logic [31:0] tx_wdata_i = '0, rx_wdata_i = '0;
  logic        tx_valid_o, rx_ready_o, tx_empty_o, tx_full_o, rx_empty_o, rx_full_o;
  logic        tx_empty_set_o, rx_full_set_o, overrun_o, underrun_o;
  logic [31:0] tx_rdata_o, rx_rdata_o;
  logic [3:0]  tx_level_o, rx_level_o;
`ifdef QSPI_FIFO_FLUSH_EN
  logic        tx_flush_i = 0, rx_flush_i = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  qspi_fifo_buf dut (
    .pclk(pclk), .preset(preset),
    .tx_we_i(tx_we_i), .tx_wdata_i(tx_wdata_i), .tx_valid_o(tx_valid_o),
    .tx_rdata_o(tx_rdata_o), .tx_ready_i(tx_ready_i),
    .rx_valid_i(rx_valid_i), .rx_wdata_i(rx_wdata_i), .rx_ready_o(rx_ready_o),
    .rx_re_i(rx_re_i), .rx_rdata_o(rx_rdata_o),
    .tx_level_o(tx_level_o), .rx_level_o(rx_level_o),
    .tx_empty_o(tx_empty_o), .tx_full_o(tx_full_o),
    .rx_empty_o(rx_empty_o), .rx_full_o(rx_full_o),
    .tx_empty_set_o(tx_empty_set_o), .rx_full_set_o(rx_full_set_o),
    .overrun_o(overrun_o), .underrun_o(underrun_o),
`ifdef QSPI_FIFO_FLUSH_EN
    .tx_flush_i(tx_flush_i), .rx_flush_i(rx_flush_i),
`endif
    .err_clr_i(err_clr_i)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic fill_tx(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      tx_we_i = 1; tx_wdata_i = base + 32'(i);
      tick();
    end
    tx_we_i = 0;
  endtask

  task automatic test_reset();
    int pulses;
    preset = 1;
    repeat (2) tick();
    n_checks++;
    if ({tx_empty_o, rx_empty_o, tx_valid_o, rx_ready_o, tx_full_o, rx_full_o} !== 6'b110100) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=110100",
        {tx_empty_o, rx_empty_o, tx_valid_o, rx_ready_o, tx_full_o, rx_full_o});
    end
    n_checks++;
    if ({tx_level_o, rx_level_o, overrun_o, underrun_o, tx_empty_set_o, rx_full_set_o} !== 12'h0) begin
      n_fail++; $display("FAIL reset_levels got=%h exp=000",
        {tx_level_o, rx_level_o, overrun_o, underrun_o, tx_empty_set_o, rx_full_set_o});
    end
    n_checks++;
    if (tx_rdata_o !== 32'h0 || rx_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got=%h/%h exp=0/0", tx_rdata_o, rx_rdata_o);
    end
    preset = 0;
    pulses = 0;
    repeat (3) begin tick(); if (tx_empty_set_o) pulses++; end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL reset_release_pulse got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_tx_fill_drain();
    int pulses;
    fill_tx(32'hA0, 8);
    n_checks++;
    if (tx_full_o !== 1'b1 || tx_level_o !== 4'd8 || tx_rdata_o !== 32'hA0) begin
      n_fail++; $display("FAIL tx_fill got full=%b lvl=%0d head=%h exp 1/8/a0",
        tx_full_o, tx_level_o, tx_rdata_o);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (tx_valid_o !== 1'b1 || tx_rdata_o !== 32'hA0 + 32'(i)) begin
        n_fail++; $display("FAIL tx_drain[%0d] got=%h v=%b exp=%h", i, tx_rdata_o, tx_valid_o, 32'hA0 + 32'(i));
      end
      tx_ready_i = 1;
      tick();
      if (tx_empty_set_o) pulses++;
    end
    tx_ready_i = 0;
    repeat (3) begin tick(); if (tx_empty_set_o) pulses++; end
    n_checks++;
    if (pulses !== 1 || tx_empty_o !== 1'b1 || tx_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL tx_empty_pulse got pulses=%0d empty=%b data=%h exp 1/1/0",
        pulses, tx_empty_o, tx_rdata_o);
    end
  endtask

  task automatic test_overrun();
    fill_tx(32'hB0, 8);
    tx_we_i = 1; tx_wdata_i = 32'hDEAD;
    tick();
    tx_we_i = 0;
    n_checks++;
    if (overrun_o !== 1'b1 || tx_level_o !== 4'd8) begin
      n_fail++; $display("FAIL tx_overrun got ovr=%b lvl=%0d exp 1/8", overrun_o, tx_level_o);
    end
    err_clr_i = 1; tick(); err_clr_i = 0;
    n_checks++;
    if (overrun_o !== 1'b0) begin
      n_fail++; $display("FAIL err_clr got=%b exp=0", overrun_o);
    end
    tx_we_i = 1; err_clr_i = 1; tick(); tx_we_i = 0; err_clr_i = 0;
    n_checks++;
    if (overrun_o !== 1'b1) begin
      n_fail++; $display("FAIL set_beats_clr got=%b exp=1", overrun_o);
    end
    err_clr_i = 1; tick(); err_clr_i = 0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (tx_rdata_o !== 32'hB0 + 32'(i)) begin
        n_fail++; $display("FAIL ovr_drain[%0d] got=%h exp=%h", i, tx_rdata_o, 32'hB0 + 32'(i));
      end
      tx_ready_i = 1; tick();
    end
    tx_ready_i = 0;
    n_checks++;
    if (tx_level_o !== 4'd0 || overrun_o !== 1'b0) begin
      n_fail++; $display("FAIL ovr_end got lvl=%0d ovr=%b exp 0/0", tx_level_o, overrun_o);
    end
  endtask

  task automatic test_push_pop_full();
    fill_tx(32'hC0, 8);
    tx_we_i = 1; tx_wdata_i = 32'h55; tx_ready_i = 1;
    tick();
    tx_we_i = 0; tx_ready_i = 0;
    n_checks++;
    if (tx_level_o !== 4'd8 || overrun_o !== 1'b0 || tx_rdata_o !== 32'hC1) begin
      n_fail++; $display("FAIL full_pushpop got lvl=%0d ovr=%b head=%h exp 8/0/c1",
        tx_level_o, overrun_o, tx_rdata_o);
    end
    for (int i = 1; i < 9; i++) begin
      n_checks++;
      if (tx_rdata_o !== ((i == 8) ? 32'h55 : 32'hC0 + 32'(i))) begin
        n_fail++; $display("FAIL full_pushpop_drain[%0d] got=%h", i, tx_rdata_o);
      end
      tx_ready_i = 1; tick();
    end
    tx_ready_i = 0;
  endtask

  task automatic test_empty_push_pop();
    tx_we_i = 1; tx_wdata_i = 32'h77; tx_ready_i = 1;
    tick();
    tx_we_i = 0; tx_ready_i = 0;
    n_checks++;
    if (tx_level_o !== 4'd1 || tx_rdata_o !== 32'h77) begin
      n_fail++; $display("FAIL empty_pushpop got lvl=%0d head=%h exp 1/77", tx_level_o, tx_rdata_o);
    end
    tx_ready_i = 1; tick(); tx_ready_i = 0;
    repeat (2) tick();
  endtask

  task automatic test_rx();
    int pulses;
    rx_re_i = 1;
    #1;
    n_checks++;
    if (rx_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL rx_empty_read got=%h exp=0", rx_rdata_o);
    end
    tick();
    rx_re_i = 0;
    n_checks++;
    if (underrun_o !== 1'b1 || rx_level_o !== 4'd0) begin
      n_fail++; $display("FAIL rx_underrun got unr=%b lvl=%0d exp 1/0", underrun_o, rx_level_o);
    end
    err_clr_i = 1; tick(); err_clr_i = 0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      rx_valid_i = 1; rx_wdata_i = 32'hD0 + 32'(i);
      tick();
      if (rx_full_set_o) pulses++;
    end
    rx_valid_i = 0;
    repeat (3) begin tick(); if (rx_full_set_o) pulses++; end
    n_checks++;
    if (pulses !== 1 || rx_ready_o !== 1'b0 || rx_full_o !== 1'b1 || rx_level_o !== 4'd8) begin
      n_fail++; $display("FAIL rx_full got pulses=%0d rdy=%b full=%b lvl=%0d exp 1/0/1/8",
        pulses, rx_ready_o, rx_full_o, rx_level_o);
    end
    n_checks++;
    if (underrun_o !== 1'b0) begin
      n_fail++; $display("FAIL rx_unr_clr got=%b exp=0", underrun_o);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rx_rdata_o !== 32'hD0 + 32'(i)) begin
        n_fail++; $display("FAIL rx_drain[%0d] got=%h exp=%h", i, rx_rdata_o, 32'hD0 + 32'(i));
      end
      rx_re_i = 1; tick();
    end
    rx_re_i = 0;
    n_checks++;
    if (rx_empty_o !== 1'b1 || underrun_o !== 1'b0) begin
      n_fail++; $display("FAIL rx_end got empty=%b unr=%b exp 1/0", rx_empty_o, underrun_o);
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      fill_tx(32'hE0 + 32'(r * 8), 5);
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (tx_rdata_o !== 32'hE0 + 32'(r * 8 + i)) begin
          n_fail++; $display("FAIL wrap[%0d][%0d] got=%h exp=%h", r, i, tx_rdata_o, 32'hE0 + 32'(r * 8 + i));
        end
        tx_ready_i = 1; tick();
      end
      tx_ready_i = 0;
    end
    n_checks++;
    if (tx_level_o !== 4'd0) begin
      n_fail++; $display("FAIL wrap_level got=%0d exp=0", tx_level_o);
    end
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    int pulses;
    fill_tx(32'hF0, 4);
    n_checks++;
    if (tx_level_o !== 4'd4) begin
      n_fail++; $display("FAIL pre_reset_level got=%0d exp=4", tx_level_o);
    end
    #2 preset = 1;
    #1;
    n_checks++;
    if (tx_level_o !== 4'd0 || tx_empty_o !== 1'b1 || tx_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got lvl=%0d empty=%b valid=%b exp 0/1/0",
        tx_level_o, tx_empty_o, tx_valid_o);
    end
    tick();
    preset = 0;
    pulses = 0;
    repeat (3) begin tick(); if (tx_empty_set_o) pulses++; end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL reset_no_pulse got=%0d exp=0", pulses);
    end
`ifdef QSPI_FIFO_FLUSH_EN
    for (int i = 0; i < 6; i++) begin
      rx_valid_i = 1; rx_wdata_i = 32'h100 + 32'(i); tick();
    end
    rx_valid_i = 0;
    rx_flush_i = 1; rx_valid_i = 1; tick(); rx_flush_i = 0; rx_valid_i = 0;
    n_checks++;
    if (rx_level_o !== 4'd0 || rx_empty_o !== 1'b1) begin
      n_fail++; $display("FAIL rx_flush got lvl=%0d exp=0", rx_level_o);
    end
    fill_tx(32'h200, 3);
    tx_flush_i = 1; tick(); tx_flush_i = 0;
    pulses = 0;
    repeat (3) begin tick(); if (tx_empty_set_o) pulses++; end
    n_checks++;
    if (tx_level_o !== 4'd0 || pulses !== 1) begin
      n_fail++; $display("FAIL tx_flush got lvl=%0d pulses=%0d exp 0/1", tx_level_o, pulses);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_tx_fill_drain();
    test_overrun();
    test_push_pop_full();
    test_empty_push_pop();
    test_rx();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
